// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg: state encoding and image-size helper shared by the serial boot loader.
package boot_loader_pkg;

    typedef logic [2:0] boot_state_t;

    localparam boot_state_t S_IDLE = 3'd0;
    localparam boot_state_t S_LEN  = 3'd1;
    localparam boot_state_t S_DATA = 3'd2;
    localparam boot_state_t S_CSUM = 3'd3;
    localparam boot_state_t S_DONE = 3'd4;
    localparam boot_state_t S_ERR  = 3'd5;

    // Largest image that fits the write port: 2^addr_width words.
    function automatic logic [63:0] max_image_words(input int unsigned addr_width);
        return 64'd1 << addr_width;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: multi-flop synchroniser for an async input plus a one-cycle rising-edge pulse.
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic rise
);
    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = (sync_q << 1) | STAGES'(din);
        prev_d = sync_q[STAGES-1];
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/serial_boot_loader.sv
// serial_boot_loader: receives a length-framed image over boot_clk/boot_data and writes it to imem.
// Define BOOT_CHECKSUM_EN to require a trailing checksum word (sum of length and all data words).
module serial_boot_loader
    import boot_loader_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 12,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_req,
    input  logic                  boot_clk,
    input  logic                  boot_data,
    output logic                  boot_ready,
    output logic                  cpu_hold,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded,
    output logic [2:0]            dbg_state
);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TLIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [63:0] MAX_WORDS = max_image_words(ADDR_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
`ifdef BOOT_CHECKSUM_EN
    localparam boot_state_t S_AFTER_DATA = S_CSUM;
`else
    localparam boot_state_t S_AFTER_DATA = S_DONE;
`endif

    boot_state_t           state_q, state_d;
    logic [DATA_WIDTH-2:0] shift_q, shift_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   words_q, words_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  load_prev_q, load_prev_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
`ifdef BOOT_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
`endif

    logic                  clk_rise;
    logic                  receiving;
    logic                  word_done;
    logic [DATA_WIDTH-1:0] word_next;

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_clk_sync (
        .clock (clock),
        .reset (reset),
        .din   (boot_clk),
        .rise  (clk_rise)
    );

    // boot_data takes the same delay as boot_clk, so the synced bit lines up with clk_rise.
    assign receiving = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign word_next = {shift_q, data_sync_q[SYNC_STAGES-1]};
    assign word_done = receiving && clk_rise && (bit_cnt_q == LAST_BIT);

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        len_d       = len_q;
        words_d     = words_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        tmo_d       = tmo_q;
        load_prev_d = load_req;
        data_sync_d = (data_sync_q << 1) | SYNC_STAGES'(boot_data);
`ifdef BOOT_CHECKSUM_EN
        sum_d       = sum_q;
`endif

        if (receiving) begin
            if (clk_rise) begin
                tmo_d     = '0;
                shift_d   = word_next[DATA_WIDTH-2:0];
                bit_cnt_d = word_done ? '0 : bit_cnt_q + 1'b1;
            end else if (TIMEOUT_CYCLES != 0) begin
                if (tmo_q == TW'(TLIMIT)) state_d = S_ERR;
                else                      tmo_d   = tmo_q + 1'b1;
            end
        end

        if (word_done) begin
            case (state_q)
                S_LEN: begin
                    len_d = (ADDR_WIDTH + 1)'(word_next);
`ifdef BOOT_CHECKSUM_EN
                    sum_d = word_next;
`endif
                    if (64'(word_next) > MAX_WORDS) state_d = S_ERR;
                    else if (word_next == '0)       state_d = S_AFTER_DATA;
                    else                            state_d = S_DATA;
                end
                S_DATA: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = words_q[ADDR_WIDTH-1:0];
                    wr_data_d = word_next;
                    words_d   = words_q + 1'b1;
`ifdef BOOT_CHECKSUM_EN
                    sum_d     = sum_q + word_next;
`endif
                    if (words_q + 1'b1 == len_q) state_d = S_AFTER_DATA;
                end
`ifdef BOOT_CHECKSUM_EN
                S_CSUM: state_d = (word_next == sum_q) ? S_DONE : S_ERR;
`endif
                default: ;
            endcase
        end

        // A new load is only accepted from IDLE, DONE or ERR.
        if (!receiving && load_req && !load_prev_q) begin
            state_d   = S_LEN;
            shift_d   = '0;
            bit_cnt_d = '0;
            len_d     = '0;
            words_d   = '0;
            tmo_d     = '0;
`ifdef BOOT_CHECKSUM_EN
            sum_d     = '0;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            len_q       <= '0;
            words_q     <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            tmo_q       <= '0;
            load_prev_q <= 1'b0;
            data_sync_q <= '0;
`ifdef BOOT_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            len_q       <= len_d;
            words_q     <= words_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            tmo_q       <= tmo_d;
            load_prev_q <= load_prev_d;
            data_sync_q <= data_sync_d;
`ifdef BOOT_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    // boot_ready is a level, not a handshake: the host may clock bits whenever it is high.
    assign boot_ready   = receiving;
    assign cpu_hold     = receiving || (state_q == S_ERR);
    assign done         = (state_q == S_DONE);
    assign error        = (state_q == S_ERR);
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign words_loaded = words_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_serial_boot_loader.sv
// tb_serial_boot_loader: table-driven loads plus hand sequences for timeout, reset and ignored events.
module tb_serial_boot_loader;
    import boot_loader_pkg::*;

    localparam int DW      = 32;
    localparam int AW      = 12;
    localparam int SYNC    = 2;
    localparam int TIMEOUT = 100;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          load_req = 1'b0;
    logic          boot_clk = 1'b0;
    logic          boot_data = 1'b0;
    logic          boot_ready, cpu_hold, wr_en, done, error;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW:0]   words_loaded;
    logic [2:0]    dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [AW+DW-1:0] exp_q[$];

    serial_boot_loader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset), .load_req(load_req), .boot_clk(boot_clk),
        .boot_data(boot_data), .boot_ready(boot_ready), .cpu_hold(cpu_hold),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .done(done),
        .error(error), .words_loaded(words_loaded), .dbg_state(dbg_state)
    );

    // Clock / reset
    always #5 clock = ~clock;

    // Checking helpers
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_status(input string name, input bit e_done, input bit e_err,
                                input bit e_hold, input bit e_ready, input int e_words);
        check({name, "/done"}, 64'(done), 64'(e_done));
        check({name, "/error"}, 64'(error), 64'(e_err));
        check({name, "/cpu_hold"}, 64'(cpu_hold), 64'(e_hold));
        check({name, "/boot_ready"}, 64'(boot_ready), 64'(e_ready));
        check({name, "/words_loaded"}, 64'(words_loaded), 64'(e_words));
    endtask

    // Scoreboard: every write strobe must match the head of the expected queue.
    always @(negedge clock) begin
        if (wr_en === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", wr_addr, wr_data);
            end else begin
                logic [AW+DW-1:0] e;
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    n_errors++;
                    $display("FAIL write: got addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                             wr_addr, wr_data, e[AW+DW-1:DW], e[DW-1:0]);
                end
            end
        end
    end

    // Driver tasks (inputs change 1 time unit after the rising clock edge)
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        wait_cycles(1);
        load_req = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        boot_data = b;
        wait_cycles(2);
        boot_clk = 1'b1;
        wait_cycles(2);
        boot_clk = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] w, input int nbits);
        for (int k = DW - 1; k >= DW - nbits; k--) send_bit(w[k]);
    endtask

    task automatic expect_write(input int addr, input logic [DW-1:0] data);
        exp_q.push_back({AW'(addr), data});
    endtask

    // Vector table
    typedef struct {
        string             name;
        logic [DW-1:0]     len;
        int                n_data;
        logic [3:0][DW-1:0] data;
        bit                send_csum;
        logic [DW-1:0]     csum;
        bit                exp_done;
        bit                exp_error;
        int                exp_writes;
    } vec_t;

    function automatic vec_t mk(input string n, input logic [DW-1:0] len, input int nd,
                                input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                input logic [DW-1:0] d2, input bit sc, input logic [DW-1:0] cs,
                                input bit ed, input bit ee, input int nw);
        vec_t v;
        v.name = n; v.len = len; v.n_data = nd;
        v.data = '0; v.data[0] = d0; v.data[1] = d1; v.data[2] = d2;
        v.send_csum = sc; v.csum = cs;
        v.exp_done = ed; v.exp_error = ee; v.exp_writes = nw;
        return v;
    endfunction

    localparam int NV = 6;
    vec_t vecs[NV];
    bit   csum_on;
    int   cnt;

    initial begin
`ifdef BOOT_CHECKSUM_EN
        csum_on = 1'b1;
`else
        csum_on = 1'b0;
`endif
        // Checksums: 3+0x13+0xDEADBEEF+0x12345678 = 0xF0E2157D; 1+0xFFFFFFFF wraps to 0.
        vecs[0] = mk("good3", 32'd3, 3, 32'h00000013, 32'hDEADBEEF, 32'h12345678,
                     1'b1, 32'hF0E2157D, 1'b1, 1'b0, 3);
        vecs[1] = mk("badcsum", 32'd3, 3, 32'h00000013, 32'hDEADBEEF, 32'h12345678,
                     1'b1, 32'hF0E2157E, !csum_on, csum_on, 3);
        vecs[2] = mk("toolong", 32'd4097, 0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b1, 0);
        vecs[3] = mk("zero", 32'd0, 0, '0, '0, '0, 1'b1, 32'h00000000, 1'b1, 1'b0, 0);
        vecs[4] = mk("wrap", 32'd1, 1, 32'hFFFFFFFF, '0, '0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1);
        vecs[5] = mk("huge", 32'h80000000, 0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b1, 0);

        wait_cycles(3);
        check_status("reset", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("reset/wr_en", 64'(wr_en), 64'd0);
        check("reset/state", 64'(dbg_state), 64'(S_IDLE));
        reset = 1'b0;
        wait_cycles(2);

        for (int i = 0; i < NV; i++) begin
            pulse_load();
            check_status({vecs[i].name, "/start"}, 1'b0, 1'b0, 1'b1, 1'b1, 0);
            check({vecs[i].name, "/start_state"}, 64'(dbg_state), 64'(S_LEN));
            send_word(vecs[i].len, DW);
            for (int j = 0; j < vecs[i].n_data; j++) begin
                if (j < vecs[i].exp_writes) expect_write(j, vecs[i].data[j]);
                send_word(vecs[i].data[j], DW);
            end
            if (csum_on && vecs[i].send_csum) send_word(vecs[i].csum, DW);
            wait_cycles(6);
            check_status({vecs[i].name, "/end"}, vecs[i].exp_done, vecs[i].exp_error,
                         !vecs[i].exp_done, 1'b0, vecs[i].exp_writes);
            check({vecs[i].name, "/pending_writes"}, 64'(exp_q.size()), 64'd0);
        end

        // Serial traffic while DONE must be ignored.
        pulse_load();
        send_word(32'd0, DW);
        if (csum_on) send_word(32'd0, DW);
        wait_cycles(6);
        check_status("done_idle/before", 1'b1, 1'b0, 1'b0, 1'b0, 0);
        send_word(32'h00000005, DW);
        wait_cycles(6);
        check_status("done_idle/after", 1'b1, 1'b0, 1'b0, 1'b0, 0);

        // Timeout: host stops after 10 bits of the second word.
        pulse_load();
        send_word(32'd3, DW);
        expect_write(0, 32'hCAFEF00D);
        send_word(32'hCAFEF00D, DW);
        send_word(32'h5A5A5A5A, 9);
        boot_data = 1'b1;
        wait_cycles(2);
        boot_clk = 1'b1;
        cnt = 0;
        while (cnt < 300 && error !== 1'b1) begin
            wait_cycles(1);
            cnt++;
            if (cnt == 2) boot_clk = 1'b0;
        end
        check("timeout/cycles", 64'(cnt), 64'(SYNC + 1 + TIMEOUT));
        check_status("timeout/end", 1'b0, 1'b1, 1'b1, 1'b0, 1);
        check("timeout/pending_writes", 64'(exp_q.size()), 64'd0);

        // Mid-load load_req is ignored; reset after the 2nd write aborts the load.
        pulse_load();
        send_word(32'd3, DW);
        expect_write(0, 32'h11111111);
        send_word(32'h11111111, DW);
        wait_cycles(4);
        pulse_load();
        wait_cycles(2);
        check_status("midload_req", 1'b0, 1'b0, 1'b1, 1'b1, 1);
        expect_write(1, 32'h22222222);
        send_word(32'h22222222, DW);
        wait_cycles(4);
        check("pre_reset/words_loaded", 64'(words_loaded), 64'd2);
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        check_status("midreset", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("midreset/wr_en", 64'(wr_en), 64'd0);
        check("midreset/wr_addr", 64'(wr_addr), 64'd0);
        check("midreset/wr_data", 64'(wr_data), 64'd0);
        check("midreset/state", 64'(dbg_state), 64'(S_IDLE));
        send_word(32'h33333333, DW);
        wait_cycles(6);
        check_status("after_reset_bits", 1'b0, 1'b0, 1'b0, 1'b0, 0);

        // Fresh L=2 load; checksum 2+0xA5A5A5A5+0x0000FFFF = 0xA5A6A5A6.
        pulse_load();
        send_word(32'd2, DW);
        expect_write(0, 32'hA5A5A5A5);
        send_word(32'hA5A5A5A5, DW);
        expect_write(1, 32'h0000FFFF);
        send_word(32'h0000FFFF, DW);
        if (csum_on) send_word(32'hA5A6A5A6, DW);
        wait_cycles(6);
        check_status("reload2", 1'b1, 1'b0, 1'b0, 1'b0, 2);
        check("reload2/pending_writes", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
